mux_bin_pipe: RTL and testbench
===============================

Name: mux_bin_pipe

Overview:
Pipelined binary-select multiplexer with a valid/ready handshake. It selects one element of an unpacked array by a binary index. The select is built as a radix-RADIX mux tree cut into register stages, so wide arrays close timing. It sits between a producer issuing {index, array} transactions and a consumer that can stall.

Parameters:
DAT_T, logic [4-1:0], element data type
WIDTH, 32, number of array elements (≥2, need not be a power of RADIX)
RADIX, 2, tree node fan-in (2 or 4)
SPLIT, 1, tree levels per pipeline stage (≥1)
WIDTH_LOG (local), $clog2(WIDTH), select width
LEVELS (local), ceil(log_RADIX(WIDTH)), tree depth
STAGES (local), ceil(LEVELS/SPLIT), register stages = latency

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
s_vld  input  1  input transaction valid
s_rdy  output  1  input ready
s_bin  input  WIDTH_LOG  binary select
s_ary  input  DAT_T [WIDTH]  data array, unpacked [WIDTH-1:0]
m_vld  output  1  output valid
m_rdy  input  1  output ready
m_dat  output  DAT_T  selected element

Behaviour:
- Reset (async assert, sync release): all stage valid bits = 0, all data and select registers = 0. m_vld = 0, m_dat = 0. s_rdy = 1 as soon as reset deasserts.
- Tree: leaves padded with DAT_T'('0) up to RADIX**LEVELS. Level k consumes select digit k, LSB digit first. Each digit is log2(RADIX) bits of s_bin, zero-extended to LEVELS*log2(RADIX) bits.
- Stage s holds SPLIT levels (last stage may hold fewer). It registers the reduced partial array and the remaining upper select bits. The final stage registers a single DAT_T, driven on m_dat.
- Out-of-range select (s_bin ≥ WIDTH): m_dat = 0. No error flag.
- Handshake: a transfer occurs on a cycle with vld & rdy at a port. Once m_vld is 1, m_vld and m_dat hold stable until m_rdy.
- Per-stage valid v[s]. Stage s loads when !v[s] | adv[s+1], with adv[STAGES] = m_rdy. s_rdy = !v[0] | adv[1].
- The ready chain is combinational, so bubbles collapse. There is no skid buffer.
- Latency: STAGES cycles from input transfer to m_vld with no stall. With m_rdy held 1, throughput is 1 transfer/clock.
- Stall: when m_rdy = 0 with all stages full, s_rdy = 0 and no register changes. Up to STAGES transactions are in flight.
- Simultaneous load and drain of a stage in one cycle is legal. The data is replaced and v stays 1.
- Data registers load only when their stage loads. Unloaded stages hold.
- s_bin and s_ary may change freely while s_vld = 0. While s_vld = 1 & s_rdy = 0 they must stay stable; the bench asserts this.
- Ordering: strict FIFO. No transaction is dropped or duplicated.
- Reset mid-operation: all in-flight transactions are discarded immediately, and m_vld drops asynchronously.
- Illegal parameters (RADIX ∉ {2,4}, SPLIT = 0, WIDTH < 2) trigger $fatal at elaboration.

Test Plan:
1. WIDTH=8, RADIX=2, SPLIT=1 (3 stages). Ary[i] = i+1; s_bin = 5 accepted at cycle 0, m_rdy = 1 → m_vld = 1 with m_dat = 6 at cycle 3, and only that cycle.
2. Same config, back-to-back s_bin = 0..7 with m_rdy = 1 → m_dat = 1..8 on 8 consecutive cycles. s_rdy stays 1 throughout.
3. Stall: m_rdy = 0 for 6 cycles while streaming → s_rdy falls after 3 accepts. m_dat holds 1. Releasing m_rdy drains 1,2,3 then continues in order without gaps or loss.
4. WIDTH=5, RADIX=4, SPLIT=2 (1 stage). s_bin = 4 → element 4 after 1 cycle. s_bin = 7 → m_dat = 0.
5. Reset: assert rst_n = 0 with 3 transactions in flight mid-cycle → m_vld = 0 immediately. After release, the first new transaction emerges alone with correct data.
6. Random: vld/rdy toggled at 50% with random data, 10k transactions, all four param sets → scoreboard matches ary[bin] in order. Stability assertions hold.

Source files
------------

// File: rtl/mux_bin_pipe.sv
// Pipelined binary-select multiplexer: radix-RADIX mux tree cut into register
// stages of SPLIT levels each, with a combinational valid/ready chain.
module mux_bin_pipe #(
    parameter type DAT_T = logic [4-1:0],
    parameter int  WIDTH = 32,
    parameter int  RADIX = 2,
    parameter int  SPLIT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s_vld,
    output logic                     s_rdy,
    input  logic [$clog2(WIDTH)-1:0] s_bin,
    input  DAT_T                     s_ary [WIDTH-1:0],
    output logic                     m_vld,
    input  logic                     m_rdy,
    output DAT_T                     m_dat
);

    localparam int WIDTH_LOG = $clog2(WIDTH);
    localparam int DW        = $bits(DAT_T);
    localparam int DIG       = (RADIX == 4) ? 2 : 1;
    localparam int LEVELS    = (WIDTH_LOG + DIG - 1) / DIG;
    localparam int SPLIT_SAFE = (SPLIT < 1) ? 1 : SPLIT;
    localparam int STAGES    = (LEVELS + SPLIT_SAFE - 1) / SPLIT_SAFE;

    if (RADIX != 2 && RADIX != 4) begin : g_bad_radix
        $fatal(1, "mux_bin_pipe: RADIX must be 2 or 4");
    end
    if (SPLIT < 1) begin : g_bad_split
        $fatal(1, "mux_bin_pipe: SPLIT must be at least 1");
    end
    if (WIDTH < 2) begin : g_bad_width
        $fatal(1, "mux_bin_pipe: WIDTH must be at least 2");
    end

    for (genvar gi = 0; gi < STAGES; gi++) begin : gen_stage
        localparam int L0   = gi * SPLIT_SAFE;
        localparam int L1   = ((gi + 1) * SPLIT_SAFE < LEVELS) ? (gi + 1) * SPLIT_SAFE : LEVELS;
        localparam int NL   = L1 - L0;
        localparam int SIN  = (LEVELS - L0) * DIG;
        localparam int SOUT = (LEVELS - L1) * DIG;
        localparam int NIN  = 1 << SIN;
        localparam int NOUT = 1 << SOUT;
        localparam int PW   = SOUT + NOUT * DW;

        logic [NIN*DW-1:0]  din;
        logic [SIN-1:0]     sin;
        logic [NOUT*DW-1:0] dred;
        logic [PW-1:0]      pnext;
        logic [PW-1:0]      pipe_reg;
        logic               vld_up;
        logic               vld_reg;
        logic               rdy_dn;
        logic               rdy;

        // Stage 0 pads the array with zeros so out-of-range selects yield 0.
        if (gi == 0) begin : g_src
            assign vld_up = s_vld;
            assign sin    = SIN'(s_bin);
            for (genvar ei = 0; ei < NIN; ei++) begin : gen_pad
                if (ei < WIDTH) begin : g_elem
                    assign din[ei*DW +: DW] = s_ary[ei];
                end else begin : g_zero
                    assign din[ei*DW +: DW] = '0;
                end
            end
        end else begin : g_chain
            assign vld_up = gen_stage[gi-1].vld_reg;
            assign din    = gen_stage[gi-1].pipe_reg[NIN*DW-1:0];
            assign sin    = gen_stage[gi-1].pipe_reg[NIN*DW +: SIN];
        end

        for (genvar li = 0; li < NL; li++) begin : gen_lvl
            localparam int NI = 1 << (SIN - li * DIG);
            localparam int NO = NI >> DIG;

            logic [NI*DW-1:0] lin;
            logic [NO*DW-1:0] lout;
            logic [DIG-1:0]   dig;

            assign dig = sin[li*DIG +: DIG];

            if (li == 0) begin : g_first
                assign lin = din;
            end else begin : g_next
                assign lin = gen_lvl[li-1].lout;
            end

            always_comb begin
                lout = '0;
                for (int j = 0; j < NO; j++) begin
                    lout[j*DW +: DW] = lin[(j * RADIX + int'(dig)) * DW +: DW];
                end
            end
        end

        assign dred = gen_lvl[NL-1].lout;

        // Unconsumed upper select digits travel with the partial array.
        if (SOUT > 0) begin : g_keep_sel
            assign pnext = {sin[SIN-1 -: SOUT], dred};
        end else begin : g_drop_sel
            assign pnext = dred;
        end

        if (gi == STAGES - 1) begin : g_last
            assign rdy_dn = m_rdy;
        end else begin : g_mid
            assign rdy_dn = gen_stage[gi+1].rdy;
        end

        assign rdy = !vld_reg || rdy_dn;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld_reg  <= 1'b0;
                pipe_reg <= '0;
            end else if (rdy) begin
                vld_reg <= vld_up;
                if (vld_up) begin
                    pipe_reg <= pnext;
                end
            end
        end
    end

    assign s_rdy = gen_stage[0].rdy;
    assign m_vld = gen_stage[STAGES-1].vld_reg;
    assign m_dat = DAT_T'(gen_stage[STAGES-1].pipe_reg);

endmodule

// File: tb/tb_mux_bin_pipe.sv
// Directed and randomized checks of mux_bin_pipe over four parameter sets.
module tb_mux_bin_pipe;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    // Per-DUT handshake bits: 0=(8,2,1) 1=(5,4,2) 2=(32,2,2) 3=(13,4,1)
    logic [3:0]      vld;
    logic [3:0]      srdy;
    logic [3:0]      mv;
    logic [3:0]      mr;
    logic [3:0][3:0] md;

    logic [2:0] bin_a;
    logic [2:0] bin_b;
    logic [4:0] bin_c;
    logic [3:0] bin_d;
    logic [3:0] ary_a [7:0];
    logic [3:0] ary_b [4:0];
    logic [3:0] ary_c [31:0];
    logic [3:0] ary_d [12:0];

    int errors = 0;
    int checks = 0;

    logic [3:0] sb [4][16];
    int         wr [4];
    int         rd [4];

    mux_bin_pipe #(.DAT_T(logic [3:0]), .WIDTH(8), .RADIX(2), .SPLIT(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .s_vld(vld[0]), .s_rdy(srdy[0]), .s_bin(bin_a),
        .s_ary(ary_a), .m_vld(mv[0]), .m_rdy(mr[0]), .m_dat(md[0])
    );
    mux_bin_pipe #(.DAT_T(logic [3:0]), .WIDTH(5), .RADIX(4), .SPLIT(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .s_vld(vld[1]), .s_rdy(srdy[1]), .s_bin(bin_b),
        .s_ary(ary_b), .m_vld(mv[1]), .m_rdy(mr[1]), .m_dat(md[1])
    );
    mux_bin_pipe #(.DAT_T(logic [3:0]), .WIDTH(32), .RADIX(2), .SPLIT(2)) dut_c (
        .clk(clk), .rst_n(rst_n), .s_vld(vld[2]), .s_rdy(srdy[2]), .s_bin(bin_c),
        .s_ary(ary_c), .m_vld(mv[2]), .m_rdy(mr[2]), .m_dat(md[2])
    );
    mux_bin_pipe #(.DAT_T(logic [3:0]), .WIDTH(13), .RADIX(4), .SPLIT(1)) dut_d (
        .clk(clk), .rst_n(rst_n), .s_vld(vld[3]), .s_rdy(srdy[3]), .s_bin(bin_d),
        .s_ary(ary_d), .m_vld(mv[3]), .m_rdy(mr[3]), .m_dat(md[3])
    );

    // Reference: the selected element, or 0 when the index is past the array.
    function automatic logic [3:0] model(int k);
        case (k)
            0:       return ary_a[bin_a];
            1:       return (bin_b < 3'd5) ? ary_b[bin_b] : 4'h0;
            2:       return ary_c[bin_c];
            default: return (bin_d < 4'd13) ? ary_d[bin_d] : 4'h0;
        endcase
    endfunction

    task automatic rand_src(int k);
        case (k)
            0: begin
                bin_a = 3'($urandom_range(0, 7));
                for (int i = 0; i < 8; i++) ary_a[i] = 4'($urandom);
            end
            1: begin
                bin_b = 3'($urandom_range(0, 7));
                for (int i = 0; i < 5; i++) ary_b[i] = 4'($urandom);
            end
            2: begin
                bin_c = 5'($urandom_range(0, 31));
                for (int i = 0; i < 32; i++) ary_c[i] = 4'($urandom);
            end
            default: begin
                bin_d = 4'($urandom_range(0, 15));
                for (int i = 0; i < 13; i++) ary_d[i] = 4'($urandom);
            end
        endcase
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        vld   = '0;
        mr    = '1;
        bin_a = '0; bin_b = '0; bin_c = '0; bin_d = '0;
        for (int i = 0; i < 8; i++)  ary_a[i] = 4'(i + 1);
        for (int i = 0; i < 5; i++)  ary_b[i] = 4'hA + 4'(i);
        for (int i = 0; i < 32; i++) ary_c[i] = '0;
        for (int i = 0; i < 13; i++) ary_d[i] = '0;
        repeat (3) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (mv[k] !== 1'b0) begin
                errors++;
                $display("FAIL reset_vld dut%0d: got %0b want 0", k, mv[k]);
            end
            checks++;
            if (md[k] !== 4'h0) begin
                errors++;
                $display("FAIL reset_dat dut%0d: got %0h want 0", k, md[k]);
            end
        end
        rst_n = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (srdy[k] !== 1'b1) begin
                errors++;
                $display("FAIL reset_rdy dut%0d: got %0b want 1", k, srdy[k]);
            end
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        bin_a  = 3'd5;
        vld[0] = 1'b1;
        mr[0]  = 1'b1;
        #1;
        checks++;
        if (srdy[0] !== 1'b1) begin
            errors++;
            $display("FAIL single_accept: got %0b want 1", srdy[0]);
        end
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            vld[0] = 1'b0;
            #1;
            checks++;
            if (mv[0] !== (c == 3)) begin
                errors++;
                $display("FAIL single_vld c%0d: got %0b want %0b", c, mv[0], (c == 3));
            end
            if (c == 3) begin
                checks++;
                if (md[0] !== 4'd6) begin
                    errors++;
                    $display("FAIL single_dat: got %0h want 6", md[0]);
                end
                $display("txn single: bin=5 dat=%0h", md[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            vld[0] = (c < 8);
            bin_a  = 3'(c);
            #1;
            checks++;
            if (srdy[0] !== 1'b1) begin
                errors++;
                $display("FAIL b2b_rdy c%0d: got %0b want 1", c, srdy[0]);
            end
            checks++;
            if (mv[0] !== (c >= 3 && c <= 10)) begin
                errors++;
                $display("FAIL b2b_vld c%0d: got %0b want %0b", c, mv[0], (c >= 3 && c <= 10));
            end
            if (c >= 3 && c <= 10) begin
                checks++;
                if (md[0] !== 4'(c - 2)) begin
                    errors++;
                    $display("FAIL b2b_dat c%0d: got %0h want %0h", c, md[0], 4'(c - 2));
                end
                $display("txn b2b: c=%0d dat=%0h", c, md[0]);
            end
        end
    endtask

    task automatic test_stall();
        int idx;
        idx = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            mr[0]  = (c >= 6);
            vld[0] = (idx < 8);
            bin_a  = 3'(idx);
            #1;
            if (c < 3 || c == 6) begin
                checks++;
                if (srdy[0] !== 1'b1) begin
                    errors++;
                    $display("FAIL stall_rdy c%0d: got %0b want 1", c, srdy[0]);
                end
            end else if (c < 6) begin
                checks++;
                if (srdy[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL stall_rdy c%0d: got %0b want 0", c, srdy[0]);
                end
            end
            checks++;
            if (mv[0] !== (c >= 3 && c <= 13)) begin
                errors++;
                $display("FAIL stall_vld c%0d: got %0b want %0b", c, mv[0], (c >= 3 && c <= 13));
            end
            if (c >= 3 && c <= 13) begin
                checks++;
                if (md[0] !== ((c < 6) ? 4'd1 : 4'(c - 5))) begin
                    errors++;
                    $display("FAIL stall_dat c%0d: got %0h want %0h", c, md[0],
                             (c < 6) ? 4'd1 : 4'(c - 5));
                end
                if (c >= 6) $display("txn stall: c=%0d dat=%0h", c, md[0]);
            end
            if (vld[0] && srdy[0]) idx++;
        end
        vld[0] = 1'b0;
        mr[0]  = 1'b1;
    endtask

    task automatic test_radix4();
        logic [2:0] bl [5];
        logic [3:0] ex [5];
        bl = '{3'd4, 3'd7, 3'd5, 3'd2, 3'd0};
        ex = '{4'hE, 4'h0, 4'h0, 4'hC, 4'hA};
        mr[1] = 1'b1;
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            vld[1] = (c < 5);
            bin_b  = (c < 5) ? bl[c] : 3'd0;
            #1;
            checks++;
            if (mv[1] !== (c >= 1 && c <= 5)) begin
                errors++;
                $display("FAIL r4_vld c%0d: got %0b want %0b", c, mv[1], (c >= 1 && c <= 5));
            end
            if (c >= 1 && c <= 5) begin
                checks++;
                if (md[1] !== ex[c-1]) begin
                    errors++;
                    $display("FAIL r4_dat c%0d: got %0h want %0h", c, md[1], ex[c-1]);
                end
                $display("txn radix4: bin=%0d dat=%0h", bl[c-1], md[1]);
            end
        end
        vld[1] = 1'b0;
    endtask

    task automatic test_reset_flight();
        mr[0] = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vld[0] = 1'b1;
            bin_a  = 3'(c + 1);
        end
        @(negedge clk);
        vld[0] = 1'b0;
        #1;
        checks++;
        if (mv[0] !== 1'b1 || md[0] !== 4'd2) begin
            errors++;
            $display("FAIL flight_head: got vld=%0b dat=%0h want vld=1 dat=2", mv[0], md[0]);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (mv[0] !== 1'b0 || md[0] !== 4'd0) begin
            errors++;
            $display("FAIL flight_async: got vld=%0b dat=%0h want vld=0 dat=0", mv[0], md[0]);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        mr[0]  = 1'b1;
        vld[0] = 1'b1;
        bin_a  = 3'd6;
        #1;
        checks++;
        if (srdy[0] !== 1'b1) begin
            errors++;
            $display("FAIL flight_rdy: got %0b want 1", srdy[0]);
        end
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            vld[0] = 1'b0;
            #1;
            checks++;
            if (mv[0] !== (c == 3) || (c == 3 && md[0] !== 4'd7)) begin
                errors++;
                $display("FAIL flight_new c%0d: got vld=%0b dat=%0h want vld=%0b dat=7",
                         c, mv[0], md[0], (c == 3));
            end
        end
    endtask

    task automatic test_random();
        int   sent [4];
        int   got  [4];
        logic held [4];
        logic stall_prev [4];
        logic [3:0] last_md [4];
        int   cyc;
        bit   done;
        for (int k = 0; k < 4; k++) begin
            sent[k] = 0; got[k] = 0; wr[k] = 0; rd[k] = 0;
            held[k] = 1'b0; stall_prev[k] = 1'b0; last_md[k] = '0;
        end
        cyc  = 0;
        done = 1'b0;
        while (!done && cyc < 40000) begin
            @(negedge clk);
            cyc++;
            for (int k = 0; k < 4; k++) begin
                if (!held[k]) begin
                    rand_src(k);
                    vld[k] = (sent[k] < 2500) && ($urandom_range(0, 1) == 1);
                end
                mr[k] = ($urandom_range(0, 1) == 1);
            end
            #1;
            done = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (stall_prev[k]) begin
                    checks++;
                    if (mv[k] !== 1'b1 || md[k] !== last_md[k]) begin
                        errors++;
                        $display("FAIL rand_hold dut%0d: got vld=%0b dat=%0h want vld=1 dat=%0h",
                                 k, mv[k], md[k], last_md[k]);
                    end
                end
                if (mv[k] && mr[k]) begin
                    checks++;
                    if (rd[k] == wr[k]) begin
                        errors++;
                        $display("FAIL rand_spurious dut%0d: got dat=%0h want no output", k, md[k]);
                    end else begin
                        if (md[k] !== sb[k][rd[k] % 16]) begin
                            errors++;
                            $display("FAIL rand_dat dut%0d n%0d: got %0h want %0h",
                                     k, got[k], md[k], sb[k][rd[k] % 16]);
                        end
                        rd[k]++;
                    end
                    got[k]++;
                end
                held[k] = vld[k] && !srdy[k];
                if (vld[k] && srdy[k]) begin
                    sb[k][wr[k] % 16] = model(k);
                    wr[k]++;
                    sent[k]++;
                end
                stall_prev[k] = mv[k] && !mr[k];
                last_md[k]    = md[k];
                if (got[k] < 2500) done = 1'b0;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL rand_timeout: got %0d/%0d/%0d/%0d outputs want 2500 each",
                     got[0], got[1], got[2], got[3]);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (rd[k] != wr[k]) begin
                errors++;
                $display("FAIL rand_leftover dut%0d: got %0d pending want 0", k, wr[k] - rd[k]);
            end
        end
        vld = '0;
        mr  = '1;
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_radix4();
        test_reset_flight();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
